// File: rtl/mem_write_buffer_if.sv
// rtl/mem_write_buffer_if.sv - CPU memory port and wait-stated bus signals of the write buffer
interface mem_write_buffer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] i_mem_addr;
    logic              i_mem_rd;
    logic              i_mem_wr;
    logic [DATA_W-1:0] i_mem_wrdata;
    logic [DATA_W-1:0] o_mem_rddata;
    logic              o_mem_stall;
    logic [ADDR_W-1:0] o_bus_addr;
    logic              o_bus_rd;
    logic              o_bus_wr;
    logic [DATA_W-1:0] o_bus_wrdata;
    logic              i_bus_waitrequest;
    logic [DATA_W-1:0] i_bus_rddata;

    modport slave (
        input  i_mem_addr, i_mem_rd, i_mem_wr, i_mem_wrdata, i_bus_waitrequest, i_bus_rddata,
        output o_mem_rddata, o_mem_stall, o_bus_addr, o_bus_rd, o_bus_wr, o_bus_wrdata
    );

    modport master (
        output i_mem_addr, i_mem_rd, i_mem_wr, i_mem_wrdata, i_bus_waitrequest, i_bus_rddata,
        input  o_mem_rddata, o_mem_stall, o_bus_addr, o_bus_rd, o_bus_wr, o_bus_wrdata
    );
endinterface

// File: rtl/mem_write_buffer.sv
// rtl/mem_write_buffer.sv - posted-write FIFO with youngest-match load forwarding and blocking bus reads
module mem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_write_buffer_if.slave mif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              rd_req, full, miss, push, pop;

    // Scan oldest to youngest so the last match wins; the head stays searchable while on the bus.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q && addr_q[idx] == mif.i_mem_addr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign rd_req = mif.i_mem_rd & ~mif.i_mem_wr;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign miss   = rd_req & ~hit;
    assign push   = reset & mif.i_mem_wr & ~full;
    assign pop    = reset & (state_q == S_WR) & ~mif.i_bus_waitrequest;

    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (miss)                     state_d = S_RD_REQ;
                else if (count_q != '0)       state_d = S_WR;
            end
            S_WR:      if (!mif.i_bus_waitrequest) state_d = S_IDLE;
            S_RD_REQ:  if (!mif.i_bus_waitrequest) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                rd_data_d = mif.i_bus_rddata;
                state_d   = S_RD_DONE;
            end
            S_RD_DONE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= mif.i_mem_addr;
            data_q[wr_ptr_q] <= mif.i_mem_wrdata;
        end
    end

    // A full buffer stalls writes even in a cycle that pops; misses stall until RD_DONE.
    always_comb begin
        mif.o_mem_stall  = 1'b0;
        mif.o_mem_rddata = hit ? hit_data : rd_data_q;
        mif.o_bus_rd     = 1'b0;
        mif.o_bus_wr     = 1'b0;
        mif.o_bus_addr   = '0;
        mif.o_bus_wrdata = '0;
        if (mif.i_mem_wr)                       mif.o_mem_stall = full;
        else if (miss && state_q != S_RD_DONE)  mif.o_mem_stall = 1'b1;
        if (state_q == S_WR) begin
            mif.o_bus_wr     = 1'b1;
            mif.o_bus_addr   = addr_q[rd_ptr_q];
            mif.o_bus_wrdata = data_q[rd_ptr_q];
        end else if (state_q == S_RD_REQ) begin
            mif.o_bus_rd   = 1'b1;
            mif.o_bus_addr = mif.i_mem_addr;
        end
        if (!reset) begin
            mif.o_mem_stall  = 1'b0;
            mif.o_mem_rddata = '0;
            mif.o_bus_rd     = 1'b0;
            mif.o_bus_wr     = 1'b0;
            mif.o_bus_addr   = '0;
            mif.o_bus_wrdata = '0;
        end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb/tb_mem_write_buffer.sv - randomized and directed bench for mem_write_buffer against a memory-level model
module tb_mem_write_buffer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_write_buffer_if #(.ADDR_W(16), .DATA_W(16)) mif ();

    mem_write_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] golden  [logic [15:0]];
    logic [15:0] bus_mem [logic [15:0]];
    logic [31:0] expq [$];
    bit          evlog [$];

    int  cyc = 0;
    int  mode = 1;
    int  wait_left = 0;
    bit  mon_en = 0;
    bit  rd_acc = 0;
    logic [15:0] rd_acc_addr = '0;
    bit  prev_hold = 0;
    logic [33:0] prev_vec = '0;
    int  bus_rd_cnt = 0;
    int  bus_wr_cnt = 0;
    int  first_rd_cyc = -1;

    bit          cur_rd, cur_wr;
    logic [15:0] cur_addr, cur_data;
    int          start_cyc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] gold_rd(input logic [15:0] a);
        if (golden.exists(a)) return golden[a];
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic [50:0] out_vec();
        return {mif.o_mem_stall, mif.o_bus_rd, mif.o_bus_wr, mif.o_mem_rddata,
                mif.o_bus_addr, mif.o_bus_wrdata};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave: waitrequest and read data change 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (rd_acc) mif.i_bus_rddata = mem_rd(rd_acc_addr);
        else        mif.i_bus_rddata = 16'($urandom);
        if (wait_left > 0) begin
            mif.i_bus_waitrequest = 1'b1;
            wait_left--;
        end else if (mode == 0) mif.i_bus_waitrequest = 1'b0;
        else if (mode == 1)     mif.i_bus_waitrequest = 1'b1;
        else                    mif.i_bus_waitrequest = ($urandom_range(0, 3) == 0);
    end

    always @(negedge clk) begin
        logic [33:0] now;
        logic [31:0] e;
        if (!mon_en) begin
            rd_acc    = 0;
            prev_hold = 0;
        end else begin
            now = {mif.o_bus_rd, mif.o_bus_wr, mif.o_bus_addr, mif.o_bus_wrdata};
            if (prev_hold) chk("bus_hold", now, prev_vec);
            if (mif.o_bus_rd) begin
                bus_rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            rd_acc = mif.o_bus_rd && !mif.i_bus_waitrequest;
            if (rd_acc) begin
                rd_acc_addr = mif.o_bus_addr;
                evlog.push_back(1'b1);
                chk("bus_rd_addr", mif.o_bus_addr, mif.i_mem_addr);
            end
            if (mif.o_bus_wr && !mif.i_bus_waitrequest) begin
                bus_wr_cnt++;
                evlog.push_back(1'b0);
                chk("bus_wr_pending", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("bus_wr_order", {mif.o_bus_addr, mif.o_bus_wrdata}, e);
                end
                bus_mem[mif.o_bus_addr] = mif.o_bus_wrdata;
            end
            if (!mif.o_bus_rd && !mif.o_bus_wr)
                chk("bus_idle_zero", {mif.o_bus_addr, mif.o_bus_wrdata}, 0);
            prev_hold = (mif.o_bus_rd || mif.o_bus_wr) && mif.i_bus_waitrequest;
            prev_vec  = now;
        end
    end

    task automatic cpu_idle_inputs();
        mif.i_mem_rd     = 1'b0;
        mif.i_mem_wr     = 1'b0;
        mif.i_mem_addr   = '0;
        mif.i_mem_wrdata = '0;
    endtask

    task automatic cpu_start(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        cur_rd = rd; cur_wr = wr; cur_addr = a; cur_data = d;
        start_cyc = cyc;
        mif.i_mem_rd     = rd;
        mif.i_mem_wr     = wr;
        mif.i_mem_addr   = a;
        mif.i_mem_wrdata = d;
    endtask

    task automatic cpu_finish(output int cycles, output logic [15:0] rdata);
        cycles = 0;
        rdata  = '0;
        forever begin
            @(negedge clk);
            if (!mif.o_mem_stall) begin
                rdata = mif.o_mem_rddata;
                break;
            end
            @(posedge clk); #2;
            cycles++;
            if (cycles >= 100) begin
                chk("cpu_timeout", cycles, 0);
                break;
            end
        end
        if (cur_wr) begin
            golden[cur_addr] = cur_data;
            expq.push_back({cur_addr, cur_data});
        end else if (cur_rd) begin
            chk("rd_data", rdata, gold_rd(cur_addr));
        end
        @(posedge clk); #2;
        cpu_idle_inputs();
    endtask

    task automatic cpu_op(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                          output int cycles, output logic [15:0] rdata);
        cpu_start(rd, wr, a, d);
        cpu_finish(cycles, rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        mode = 0;
        for (int i = 0; i < 300 && expq.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        chk("drain_empty", expq.size(), 0);
    endtask

    initial begin
        int          cyc_n;
        logic [15:0] rd_v;
        int          snap;
        bit          seen;
        logic [2:0]  evbits;

        mif.i_mem_rd     = 1'b1;
        mif.i_mem_wr     = 1'b0;
        mif.i_mem_addr   = 16'h0010;
        mif.i_mem_wrdata = 16'h1111;
        mif.i_bus_waitrequest = 1'b1;
        mif.i_bus_rddata = 16'hFFFF;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs", out_vec(), 0);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        cpu_idle_inputs();
        mon_en = 1;
        idle(1);

        // posted write then zero-latency forwarding, with the bus frozen
        snap = bus_rd_cnt;
        cpu_op(0, 1, 16'h0010, 16'hBEEF, cyc_n, rd_v);
        chk("wr_no_stall", cyc_n, 0);
        cpu_op(1, 0, 16'h0010, 16'h0000, cyc_n, rd_v);
        chk("hit_no_stall", cyc_n, 0);
        chk("hit_data", rd_v, 16'hBEEF);
        cpu_op(0, 1, 16'h0010, 16'h1234, cyc_n, rd_v);
        cpu_op(1, 0, 16'h0010, 16'h0000, cyc_n, rd_v);
        chk("hit_youngest", rd_v, 16'h1234);
        chk("hit_no_bus_rd", bus_rd_cnt - snap, 0);
        drain();

        // full buffer: fifth write stalls until the head is accepted
        mode = 1;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            cpu_op(0, 1, 16'h0080 + 16'(i), 16'($urandom), cyc_n, rd_v);
            chk("fill_no_stall", cyc_n, 0);
        end
        cpu_start(0, 1, 16'h0090, 16'hCAFE);
        repeat (3) begin
            @(negedge clk);
            chk("full_stall", mif.o_mem_stall, 1);
            @(posedge clk); #2;
        end
        mode = 0;
        cpu_finish(cyc_n, rd_v);
        chk("full_stall_tail", cyc_n, 2);
        drain();

        // read miss: no wait, then two wait cycles
        bus_mem[16'h0100] = 16'h5A5A;
        golden[16'h0100]  = 16'h5A5A;
        first_rd_cyc = -1;
        cpu_op(1, 0, 16'h0100, 16'h0000, cyc_n, rd_v);
        chk("miss_stall_cycles", cyc_n, 3);
        chk("miss_data", rd_v, 16'h5A5A);
        chk("miss_bus_rd_cycle", first_rd_cyc - start_cyc, 1);
        idle(1);
        cpu_start(1, 0, 16'h0102, 16'h0000);
        wait_left = 2;
        cpu_finish(cyc_n, rd_v);
        chk("miss_wait2_cycles", cyc_n, 5);

        // read miss while a write is held on the bus
        mode = 1;
        idle(1);
        cpu_op(0, 1, 16'h0200, 16'h2222, cyc_n, rd_v);
        cpu_op(0, 1, 16'h0202, 16'h3333, cyc_n, rd_v);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mif.o_bus_wr;
        end
        chk("drain_wr_started", seen, 1);
        @(posedge clk); #2;
        evlog.delete();
        mode = 0;
        wait_left = 3;
        cpu_op(1, 0, 16'h0300, 16'h0000, cyc_n, rd_v);
        drain();
        chk("rd_during_wr_events", evlog.size(), 3);
        evbits = '0;
        for (int i = 0; i < 3 && i < evlog.size(); i++) evbits[2-i] = evlog[i];
        chk("rd_during_wr_order", evbits, 3'b010);

        // rd and wr together decode as a write only
        mode = 1;
        idle(1);
        snap = bus_rd_cnt;
        cpu_op(1, 1, 16'h0020, 16'h7777, cyc_n, rd_v);
        chk("rdwr_no_stall", cyc_n, 0);
        cpu_op(1, 0, 16'h0020, 16'h0000, cyc_n, rd_v);
        chk("rdwr_fwd", rd_v, 16'h7777);
        idle(3);
        chk("rdwr_no_bus_rd", bus_rd_cnt - snap, 0);
        drain();

        // random traffic over a small address window
        mode = 2;
        for (int n = 0; n < 300; n++) begin
            int op;
            op = $urandom_range(0, 2);
            cpu_op(op != 1, op != 0, 16'h0040 + 16'($urandom_range(0, 7)), 16'($urandom), cyc_n, rd_v);
        end
        drain();

        // reset in the middle of a drain discards everything buffered
        mode = 1;
        idle(1);
        for (int i = 0; i < 3; i++)
            cpu_op(0, 1, 16'h0500 + 16'(2 * i), 16'($urandom), cyc_n, rd_v);
        idle(2);
        mon_en = 0;
        mif.i_mem_rd   = 1'b1;
        mif.i_mem_addr = 16'h0600;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midreset_outputs", out_vec(), 0);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        cpu_idle_inputs();
        expq.delete();
        golden = bus_mem;
        mode = 0;
        snap = bus_wr_cnt;
        mon_en = 1;
        idle(10);
        chk("midreset_no_bus_wr", bus_wr_cnt - snap, 0);
        cpu_op(1, 0, 16'h0500, 16'h0000, cyc_n, rd_v);
        chk("midreset_miss_cycles", cyc_n, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1);
    end
endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Bridge between the single-cycle CPU's memory port and a slower, wait-stated memory bus. CPU stores are posted into a DEPTH-entry FIFO and drained in the background. CPU loads either forward the youngest matching buffered store or issue a blocking bus read. A stall output freezes the CPU (PC and register writes) while a request cannot complete in the current cycle.

## Interface
- DEPTH, 4, write-buffer entries; power of 2, at least 2
- ADDR_W, 16, address width
- DATA_W, 16, data width

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low; sampled on posedge clk, asserted when 0
- i_mem_addr  in  ADDR_W  CPU request address
- i_mem_rd  in  1  CPU read request
- i_mem_wr  in  1  CPU write request
- i_mem_wrdata  in  DATA_W  CPU write data
- o_mem_rddata  out  DATA_W  read data to CPU; valid when i_mem_rd=1, i_mem_wr=0, o_mem_stall=0
- o_mem_stall  out  1  CPU must hold all request inputs stable and not advance
- o_bus_addr  out  ADDR_W  bus address
- o_bus_rd  out  1  bus read strobe
- o_bus_wr  out  1  bus write strobe
- o_bus_wrdata  out  DATA_W  bus write data
- i_bus_waitrequest  in  1  bus not accepting; hold strobe, address and data
- i_bus_rddata  in  DATA_W  valid exactly one cycle after an accepted read

## Operation
- Request decode: i_mem_wr has precedence. With both rd and wr high, the cycle is a write only and no read is performed.
- Write:
  - If count < DEPTH: push {addr, data} at the posedge, o_mem_stall=0.
  - If full: o_mem_stall=1, no push; the write is retried each cycle.
  - A full buffer does not bypass a same-cycle pop.
- Read hit:
  - Address matches any buffered entry, including the entry currently being written on the bus.
  - o_mem_rddata = data of the youngest matching entry, combinational, o_mem_stall=0.
- Read miss: o_mem_stall=1 until the FSM reaches RD_DONE.
- Duplicate addresses are allowed in the buffer (no coalescing). Youngest-match forwarding preserves read-after-write order.
- FSM states and transitions:
  - IDLE:
    - On a read miss, go to RD_REQ. Reads have priority.
    - Otherwise, if the buffer is non-empty, go to WR.
    - Bus strobes are 0.
  - WR:
    - o_bus_wr=1; addr and data come from the FIFO head.
    - On i_bus_waitrequest=0: pop the head and go to IDLE.
  - RD_REQ:
    - o_bus_rd=1; o_bus_addr=i_mem_addr.
    - On i_bus_waitrequest=0, go to RD_WAIT.
  - RD_WAIT:
    - Register i_bus_rddata.
    - Go to RD_DONE.
  - RD_DONE:
    - o_mem_rddata = registered data; o_mem_stall=0.
    - Go to IDLE.
- A read miss that arrives while in WR waits for that write to be accepted. A started bus strobe is never withdrawn.
- o_bus_addr and o_bus_wrdata are 0 when no strobe is active.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop (non-full buffer): count unchanged.

## Timing
- Reset (reset=0 at a posedge):
  - State → IDLE, count → 0, pointers → 0, read-data register → 0.
  - Buffered writes are discarded, including a write in progress on the bus.
  - While reset=0, all outputs are 0.
- Write, not full: zero stall cycles. The first bus write appears 1 cycle after the push if the FSM is IDLE.
- Read hit: zero latency, combinational.
- Read miss, FSM in IDLE, no waitrequest:
  - Stall is asserted in cycles 0–2; o_bus_rd is high in cycle 1.
  - Data is returned in cycle 3 with stall=0.
  - Each waitrequest cycle adds 1.
- A write drain costs at least 2 cycles per entry (WR then IDLE).
- The CPU advances on the first cycle with o_mem_stall=0. The read in RD_DONE is therefore consumed exactly once.

## Test plan
- Reset: drive reset=0 for 2 cycles mid-drain with 3 entries buffered → all outputs 0, count=0; after release, no bus write occurs.
- Posted write then hit:
  - Write 0x0010←0xBEEF, then read 0x0010 with waitrequest=1 → rddata=0xBEEF, stall=0, no o_bus_rd.
  - Write 0x0010←0xBEEF, then 0x0010←0x1234 → a following read returns 0x1234.
- Full buffer: 5 back-to-back writes with waitrequest=1, DEPTH=4 → 5th write stalls until the first bus write is accepted. The bus then shows the 4 earlier writes in order, followed by the 5th.
- Read miss: read 0x0100 with the bus returning 0x5A5A, waitrequest low → stall in 3 cycles, o_bus_rd in cycle 1, rddata=0x5A5A in cycle 3. With 2 waitrequest cycles, data arrives in cycle 5.
- Read during drain: with one write in WR and waitrequest held for 3 cycles, issue a read miss to another address → o_bus_wr stays high until accepted, then o_bus_rd issues. Remaining buffered writes drain only after RD_DONE.
- rd+wr together: assert both with addr 0x0020 and data 0x7777 → one push, no bus read, stall=0.
